// File: rtl/wb_commit_pkg.sv
// Shared types and constants for the MEM/WB retire stage.
package wb_commit_pkg;
    localparam int RegNum   = 32;
    localparam int RegAddrW = 5;
    localparam int RegW     = 32;
    localparam int InstretW = 64;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    typedef logic [RegAddrW-1:0] reg_addr_t;   // RegAddrBus
    typedef logic [RegW-1:0]     reg_t;        // RegBus
    typedef logic [31:0]         inst_addr_t;  // InstAddrBus
    typedef logic [31:0]         inst_t;       // InstBus
    typedef logic [InstretW-1:0] instret_t;    // InstretBus

    localparam reg_addr_t NOPRegAddr = '0;
    localparam reg_t      ZeroWord   = '0;

    typedef struct packed {
        logic       valid;
        inst_addr_t pc;
        inst_t      inst;
        logic [3:0] wen;
        reg_addr_t  wnum;
        reg_t       wdata;
    } trace_t;

    // Stall bubbles arrive with valid set but pc cleared.
    function automatic logic retire_of(input logic valid, input inst_addr_t pc);
        return valid && (pc != '0);
    endfunction
endpackage

// File: rtl/wb_commit_if.sv
// MEM/WB-to-retire bundle: write-back, LLbit, commit info, ID read ports, trace.
interface wb_commit_if;
    import wb_commit_pkg::*;

    reg_addr_t  wb_wd;
    logic       wb_wreg;
    reg_t       wb_wdata;
    logic       wb_LLbit_we;
    logic       wb_LLbit_value;
    logic       excp_flush;
    inst_addr_t commit_pc;
    inst_t      commit_instr;
    logic       commit_valid;
    logic       re1, re2;
    reg_addr_t  raddr1, raddr2;
    reg_t       rdata1, rdata2;
    logic       LLbit_o;
    inst_addr_t debug_wb_pc;
    inst_t      debug_wb_inst;
    logic [3:0] debug_wb_rf_wen;
    reg_addr_t  debug_wb_rf_wnum;
    reg_t       debug_wb_rf_wdata;
    logic       debug_wb_valid;
    instret_t   instret;

    modport master (
        output wb_wd, wb_wreg, wb_wdata, wb_LLbit_we, wb_LLbit_value, excp_flush,
               commit_pc, commit_instr, commit_valid, re1, re2, raddr1, raddr2,
        input  rdata1, rdata2, LLbit_o, debug_wb_pc, debug_wb_inst, debug_wb_rf_wen,
               debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_valid, instret
    );
    modport slave (
        input  wb_wd, wb_wreg, wb_wdata, wb_LLbit_we, wb_LLbit_value, excp_flush,
               commit_pc, commit_instr, commit_valid, re1, re2, raddr1, raddr2,
        output rdata1, rdata2, LLbit_o, debug_wb_pc, debug_wb_inst, debug_wb_rf_wen,
               debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_valid, instret
    );
endinterface

// File: rtl/wb_commit_regfile.sv
// GPR file: one write port, two read ports bypassing the in-flight write; r0 reads zero.
module wb_commit_regfile #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata2
);
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    function automatic logic [DATA_W-1:0] rd(input logic re, input logic [AW-1:0] a);
        if (!re || a == '0)       return '0;
        else if (we && waddr == a) return wdata;
        else                       return regs[a];
    endfunction

    always_comb begin
        rdata1 = rd(re1, raddr1);
        rdata2 = rd(re2, raddr2);
    end
endmodule

// File: rtl/wb_commit.sv
// Retire stage: register-file write-back, LLbit, registered difftest trace, instret.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int NUM_REGS = RegNum,
    parameter int DATA_W   = RegW,
    parameter int CNT_W    = InstretW
) (
    input logic        clk,
    input logic        rst,
    wb_commit_if.slave bus
);
    logic             llbit_q;
    logic             retire;
    trace_t           trace_d, trace_q;
    logic [CNT_W-1:0] cnt_q;

    wb_commit_regfile #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.wb_wreg),
        .waddr  (bus.wb_wd),
        .wdata  (bus.wb_wdata),
        .re1    (bus.re1),
        .raddr1 (bus.raddr1),
        .rdata1 (bus.rdata1),
        .re2    (bus.re2),
        .raddr2 (bus.raddr2),
        .rdata2 (bus.rdata2)
    );

    // A flush kills the LL reservation even if an LL is retiring alongside it.
    always_ff @(posedge clk) begin
        if (rst == RstEnable)    llbit_q <= 1'b0;
        else if (bus.excp_flush) llbit_q <= 1'b0;
        else if (bus.wb_LLbit_we) llbit_q <= bus.wb_LLbit_value;
    end

    assign bus.LLbit_o = bus.excp_flush  ? 1'b0 :
                         bus.wb_LLbit_we ? bus.wb_LLbit_value : llbit_q;

    assign retire = retire_of(bus.commit_valid, bus.commit_pc);

    always_comb begin
        trace_d = '0;
        if (retire) begin
            trace_d.valid = 1'b1;
            trace_d.pc    = bus.commit_pc;
            trace_d.inst  = bus.commit_instr;
            trace_d.wen   = {4{bus.wb_wreg && bus.wb_wd != NOPRegAddr}};
            trace_d.wnum  = bus.wb_wd;
            trace_d.wdata = bus.wb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trace_q <= '0;
            cnt_q   <= '0;
        end else begin
            trace_q <= trace_d;
            if (retire) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.debug_wb_valid    = trace_q.valid;
    assign bus.debug_wb_pc       = trace_q.pc;
    assign bus.debug_wb_inst     = trace_q.inst;
    assign bus.debug_wb_rf_wen   = trace_q.wen;
    assign bus.debug_wb_rf_wnum  = trace_q.wnum;
    assign bus.debug_wb_rf_wdata = trace_q.wdata;
    assign bus.instret           = cnt_q;
endmodule

// File: tb/tb_wb_commit.sv
// Directed and random checks of wb_commit against a behavioural retire model.
module tb_wb_commit;
    import wb_commit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_commit_if bus();
    wb_commit dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_regs [32];
    logic        m_ll;
    logic [63:0] m_ir;
    logic        e_valid;
    logic [31:0] e_pc, e_inst, e_wdata;
    logic [3:0]  e_wen;
    logic [4:0]  e_wnum;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic re, input logic [4:0] a);
        if (!re || a == 5'd0) return 32'd0;
        if (bus.wb_wreg && bus.wb_wd == a) return bus.wb_wdata;
        return m_regs[a];
    endfunction

    task automatic idle();
        bus.wb_wd = '0; bus.wb_wreg = 0; bus.wb_wdata = '0;
        bus.wb_LLbit_we = 0; bus.wb_LLbit_value = 0; bus.excp_flush = 0;
        bus.commit_pc = '0; bus.commit_instr = '0; bus.commit_valid = 0;
        bus.re1 = 0; bus.re2 = 0; bus.raddr1 = '0; bus.raddr2 = '0;
    endtask

    // Advance the model with the presented inputs, then clock the DUT.
    task automatic tick();
        logic ret;
        ret = bus.commit_valid && (bus.commit_pc != 0);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_ll = 0; m_ir = 64'd0; ret = 0;
        end else begin
            if (bus.wb_wreg && bus.wb_wd != 0) m_regs[bus.wb_wd] = bus.wb_wdata;
            if (bus.excp_flush) m_ll = 0;
            else if (bus.wb_LLbit_we) m_ll = bus.wb_LLbit_value;
            if (ret) m_ir = m_ir + 64'd1;
        end
        e_valid = ret;
        e_pc    = ret ? bus.commit_pc : 32'd0;
        e_inst  = ret ? bus.commit_instr : 32'd0;
        e_wen   = (ret && bus.wb_wreg && bus.wb_wd != 0) ? 4'hf : 4'h0;
        e_wnum  = ret ? bus.wb_wd : 5'd0;
        e_wdata = ret ? bus.wb_wdata : 32'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_comb(input string tag);
        logic ll_exp;
        ll_exp = bus.excp_flush ? 1'b0 : bus.wb_LLbit_we ? bus.wb_LLbit_value : m_ll;
        chk({tag, ".rdata1"}, 64'(bus.rdata1), 64'(m_read(bus.re1, bus.raddr1)));
        chk({tag, ".rdata2"}, 64'(bus.rdata2), 64'(m_read(bus.re2, bus.raddr2)));
        chk({tag, ".llbit"},  64'(bus.LLbit_o), 64'(ll_exp));
    endtask

    task automatic check_trace(input string tag);
        chk({tag, ".valid"},   64'(bus.debug_wb_valid),    64'(e_valid));
        chk({tag, ".pc"},      64'(bus.debug_wb_pc),       64'(e_pc));
        chk({tag, ".inst"},    64'(bus.debug_wb_inst),     64'(e_inst));
        chk({tag, ".wen"},     64'(bus.debug_wb_rf_wen),   64'(e_wen));
        chk({tag, ".wnum"},    64'(bus.debug_wb_rf_wnum),  64'(e_wnum));
        chk({tag, ".wdata"},   64'(bus.debug_wb_rf_wdata), 64'(e_wdata));
        chk({tag, ".instret"}, bus.instret,                m_ir);
    endtask

    initial begin
        logic [4:0] a;
        logic       exp_v [5];

        // Reset state
        idle(); rst = 1; tick(); rst = 0; #1;
        check_trace("rst");
        bus.re1 = 1; bus.re2 = 1;
        for (int i = 1; i < 32; i++) begin
            bus.raddr1 = 5'(i); bus.raddr2 = 5'(32 - i); #1;
            chk("rst.r1", 64'(bus.rdata1), 64'd0);
            chk("rst.r2", 64'(bus.rdata2), 64'd0);
        end
        chk("rst.ll", 64'(bus.LLbit_o), 64'd0);

        // Same-cycle bypass, then stored value
        bus.wb_wd = 5'd5; bus.wb_wreg = 1; bus.wb_wdata = 32'hDEADBEEF;
        bus.raddr1 = 5'd5; bus.raddr2 = 5'd5; #1;
        chk("byp.now", 64'(bus.rdata1), 64'h0000_0000_DEAD_BEEF);
        check_comb("byp");
        tick(); bus.wb_wreg = 0; #1;
        chk("byp.held", 64'(bus.rdata1), 64'h0000_0000_DEAD_BEEF);
        bus.re1 = 0; #1;
        chk("byp.re0", 64'(bus.rdata1), 64'd0);
        bus.re1 = 1;

        // r0 write discarded, trace shows no write
        bus.wb_wd = 5'd0; bus.wb_wreg = 1; bus.wb_wdata = 32'h1234;
        bus.raddr1 = 5'd0; bus.commit_valid = 1; bus.commit_pc = 32'h1bff_fff0;
        bus.commit_instr = 32'h0280_0000; #1;
        chk("r0.now", 64'(bus.rdata1), 64'd0);
        tick(); idle(); bus.re1 = 1; #1;
        chk("r0.wen", 64'(bus.debug_wb_rf_wen), 64'd0);
        chk("r0.wnum", 64'(bus.debug_wb_rf_wnum), 64'd0);
        check_trace("r0");
        chk("r0.read", 64'(bus.rdata1), 64'd0);

        // LLbit: flush beats a write, then plain write
        bus.wb_LLbit_we = 1; bus.wb_LLbit_value = 1; bus.excp_flush = 1; #1;
        chk("ll.flush.now", 64'(bus.LLbit_o), 64'd0);
        tick(); idle(); #1;
        chk("ll.flush.next", 64'(bus.LLbit_o), 64'd0);
        bus.wb_LLbit_we = 1; bus.wb_LLbit_value = 1; #1;
        chk("ll.set.now", 64'(bus.LLbit_o), 64'd1);
        tick(); idle(); #1;
        chk("ll.set.next", 64'(bus.LLbit_o), 64'd1);

        // Retire stream with a bubble
        rst = 1; tick(); rst = 0;
        exp_v = '{1, 1, 1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            bus.commit_valid = 1;
            bus.commit_pc    = (i == 3) ? 32'd0 : 32'h1c00_0000 + 32'(4 * i);
            bus.commit_instr = 32'h0010_0000 + 32'(i);
            bus.wb_wreg = 1; bus.wb_wd = 5'(i + 1); bus.wb_wdata = 32'h100 * 32'(i);
            tick();
            chk("seq.valid", 64'(bus.debug_wb_valid), 64'(exp_v[i]));
            check_trace("seq");
        end
        idle(); tick();
        chk("seq.instret", bus.instret, 64'd4);

        // Random traffic with occasional mid-stream reset
        for (int n = 0; n < 400; n++) begin
            a = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 39) == 0);
            bus.wb_wd = a; bus.wb_wreg = 1'($urandom); bus.wb_wdata = $urandom;
            bus.wb_LLbit_we = 1'($urandom); bus.wb_LLbit_value = 1'($urandom);
            bus.excp_flush = ($urandom_range(0, 7) == 0);
            bus.commit_valid = ($urandom_range(0, 7) != 0);
            bus.commit_pc = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            bus.commit_instr = $urandom;
            bus.re1 = ($urandom_range(0, 5) != 0); bus.re2 = ($urandom_range(0, 5) != 0);
            bus.raddr1 = $urandom_range(0, 1) ? a : 5'($urandom_range(0, 31));
            bus.raddr2 = $urandom_range(0, 1) ? a : 5'($urandom_range(0, 31));
            #1;
            if (!rst) check_comb("rnd");
            tick();
            check_trace("rnd");
        end
        rst = 0;

        // instret wrap at 2^64-1
        idle(); #1;
        force dut.cnt_q = '1;
        #1;
        release dut.cnt_q;
        m_ir = '1;
        chk("wrap.pre", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.commit_valid = 1; bus.commit_pc = 32'h1c00_1000; bus.commit_instr = 32'h1;
        tick();
        chk("wrap.post", bus.instret, 64'd0);
        check_trace("wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
